// File: rtl/param_stream_loader.sv
// Frame-based parameter loader: waits for a header byte, captures NUM_PARAMS bytes
// into a shadow buffer and commits them atomically once the XOR checksum byte matches.
module param_stream_loader #(
  parameter int          NUM_PARAMS = 20,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic [8*NUM_PARAMS-1:0] params,
  output logic                    load_done,
  output logic                    cks_err,
  output logic [4:0]              byte_cnt
);

  typedef enum logic [2:0] {IDLE, HDR, LOAD, CHK, DONE, ERR} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_PARAMS - 1);
  localparam logic [4:0] FULL_CNT = 5'(NUM_PARAMS);

  state_t     state, state_nxt;
  logic       xfer;
  logic       commit;
  logic       cks_fail;
  logic [7:0] run_xor;
  logic [7:0] shadow [NUM_PARAMS];

  function automatic logic [4:0] sat_inc(input logic [4:0] cnt);
    return (cnt == FULL_CNT) ? cnt : cnt + 5'd1;
  endfunction

  assign xfer = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    cks_fail  = 1'b0;
    if (start) begin
      // start wins over any same-cycle byte and re-arms from every state
      state_nxt = HDR;
    end else if (xfer) begin
      case (state)
        HDR:  if (in_data == HEADER) state_nxt = LOAD;
        LOAD: if (byte_cnt == LAST_IDX) state_nxt = CHK;
        CHK: begin
          if (in_data == run_xor) begin
            state_nxt = DONE;
            commit    = 1'b1;
          end else begin
            state_nxt = ERR;
            cks_fail  = 1'b1;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == HDR) || (state_nxt == LOAD) || (state_nxt == CHK);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      params    <= '0;
      load_done <= 1'b0;
      cks_err   <= 1'b0;
      byte_cnt  <= '0;
      run_xor   <= '0;
      for (int k = 0; k < NUM_PARAMS; k++) shadow[k] <= '0;
    end else if (start) begin
      load_done <= 1'b0;
      cks_err   <= 1'b0;
      byte_cnt  <= '0;
      run_xor   <= '0;
    end else if (xfer) begin
      if (state == HDR && in_data == HEADER) begin
        byte_cnt <= '0;
        run_xor  <= '0;
      end
      if (state == LOAD) begin
        for (int k = 0; k < NUM_PARAMS; k++)
          if (byte_cnt == 5'(k)) shadow[k] <= in_data;
        run_xor  <= run_xor ^ in_data;
        byte_cnt <= sat_inc(byte_cnt);
      end
      // whole bank moves in one edge so params is never seen half-updated
      if (commit) begin
        for (int k = 0; k < NUM_PARAMS; k++) params[8*k +: 8] <= shadow[k];
        load_done <= 1'b1;
      end
      if (cks_fail) cks_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_stream_loader.sv
// Directed bench for param_stream_loader with a queue-based frame model checked every cycle.
module tb_param_stream_loader;
  localparam int         NP  = 20;
  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [159:0] F1 = 160'h1413121110_0f0e0d0c0b_0a09080706_0504030201;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic            in_ready;
  logic [8*NP-1:0] params;
  logic            load_done;
  logic            cks_err;
  logic [4:0]      byte_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  param_stream_loader #(.NUM_PARAMS(NP), .HEADER(HDR)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .params(params), .load_done(load_done), .cks_err(cks_err),
    .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  // Frame model: armed flag, header-seen flag and a queue of captured bytes.
  bit              m_active = 1'b0;
  bit              m_hdr = 1'b0;
  logic [7:0]      m_q[$];
  logic [8*NP-1:0] m_params = '0;
  bit              m_done = 1'b0;
  bit              m_err = 1'b0;

  function automatic logic [7:0] xor_of_q();
    logic [7:0] x = 8'h00;
    foreach (m_q[i]) x ^= m_q[i];
    return x;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_hdr = 0; m_q.delete(); m_params = '0; m_done = 0; m_err = 0;
    end else if (start) begin
      m_active = 1; m_hdr = 0; m_q.delete(); m_done = 0; m_err = 0;
    end else if (in_valid && m_active) begin
      if (!m_hdr) begin
        m_hdr = (in_data == HDR);
      end else if (m_q.size() < NP) begin
        m_q.push_back(in_data);
      end else begin
        if (in_data == xor_of_q()) begin
          for (int k = 0; k < NP; k++) m_params[8*k +: 8] = m_q[k];
          m_done = 1;
        end else begin
          m_err = 1;
        end
        m_active = 0;
        m_hdr = 0;
      end
    end
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 160'(in_ready), 160'(m_active));
      check("load_done", 160'(load_done), 160'(m_done));
      check("cks_err", 160'(cks_err), 160'(m_err));
      check("byte_cnt", 160'(byte_cnt), 160'(m_q.size()));
      check("params", params, m_params);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (1) begin
      ok = in_ready;
      tick();
      if (ok) break;
      n++;
      if (n > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: in_ready never 1 for byte %h", b);
        break;
      end
    end
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input logic [7:0] fill, input bit incr, input logic [7:0] cks,
                            input int gap);
    send_byte(HDR, gap);
    for (int i = 0; i < NP; i++) send_byte(incr ? 8'(i + 1) : fill, gap);
    send_byte(cks, gap);
  endtask

  initial begin
    // reset, then idle with in_valid high and no start
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b1;
    in_data  = HDR;
    repeat (10) tick();
    in_valid = 1'b0;
    check("idle_in_ready", 160'(in_ready), 160'd0);
    check("idle_params", params, 160'd0);

    // valid frame 01..14, checksum 14
    pulse_start();
    send_frame(8'h00, 1'b1, 8'h14, 0);
    check("f1_done", 160'(load_done), 160'd1);
    check("f1_params", params, F1);
    check("f1_byte0", 160'(params[7:0]), 160'h01);
    check("f1_byte19", 160'(params[159:152]), 160'h14);
    check("f1_cnt", 160'(byte_cnt), 160'd20);
    repeat (3) tick();

    // bad checksum: 20 x FF XOR to 00, 01 sent
    pulse_start();
    send_frame(8'hFF, 1'b0, 8'h01, 0);
    check("bad_err", 160'(cks_err), 160'd1);
    check("bad_done", 160'(load_done), 160'd0);
    check("bad_params", params, F1);
    tick();

    // leading junk then a frame with in_valid toggling
    pulse_start();
    send_byte(8'h00, 1);
    send_byte(8'h3C, 1);
    check("junk_cnt", 160'(byte_cnt), 160'd0);
    send_frame(8'h00, 1'b1, 8'h14, 1);
    check("tog_done", 160'(load_done), 160'd1);
    check("tog_params", params, F1);

    // partial frame aborted by start (with a colliding byte), then all-55 frame
    pulse_start();
    send_byte(HDR, 0);
    for (int i = 0; i < 7; i++) send_byte(8'(i + 16), 0);
    check("part_cnt", 160'(byte_cnt), 160'd7);
    in_valid = 1'b1;
    in_data  = 8'h77;
    pulse_start();
    in_valid = 1'b0;
    check("abort_cnt", 160'(byte_cnt), 160'd0);
    check("abort_params", params, F1);
    send_frame(8'h55, 1'b0, 8'h00, 0);
    check("p55_done", 160'(load_done), 160'd1);
    check("p55_params", params, {20{8'h55}});

    // reset in the middle of LOAD
    pulse_start();
    send_byte(HDR, 0);
    for (int i = 0; i < 10; i++) send_byte(8'hC3, 0);
    check("mid_cnt", 160'(byte_cnt), 160'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_ready", 160'(in_ready), 160'd0);
    check("rst_params", params, 160'd0);
    check("rst_cnt", 160'(byte_cnt), 160'd0);
    pulse_start();
    send_frame(8'h00, 1'b1, 8'h14, 0);
    check("post_rst_params", params, F1);
    check("post_rst_done", 160'(load_done), 160'd1);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
